mbist_controller: RTL and testbench

- March-test sequencer for the MBIST datapath.
- Drives the 3-bit pattern select `q` into the data-background decoder. Uses the decoder's combinational `data_t` output as write data and as the expected read data.
- Steps an address counter through an embedded single-port SRAM, compares read data, and reports pass/fail with the first failing address and pattern.
- Sits between the BIST enable logic (start/done) and the memory wrapper's test port.

---
 rtl/mbist_pkg.sv | 49 ++++
 rtl/mbist_addr_counter.sv | 42 ++++
 rtl/mbist_controller.sv | 216 +++++++++++++++++++++
 tb/tb_mbist_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbist_pkg
// Description : Shared states, background codes and helpers for the MBIST sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mbist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_M0_W    = 4'd1,
        ST_M1_R    = 4'd2,
        ST_M1_C    = 4'd3,
        ST_M1_W    = 4'd4,
        ST_M2_R    = 4'd5,
        ST_M2_C    = 4'd6,
        ST_M2_W    = 4'd7,
        ST_M3_R    = 4'd8,
        ST_M3_C    = 4'd9,
        ST_NEXT_BG = 4'd10,
        ST_DONE    = 4'd11
    } state_t;

    localparam logic [2:0] PAT_BG0  = 3'b000;
    localparam logic [2:0] PAT_INV0 = 3'b001;
    localparam logic [2:0] PAT_BG1  = 3'b010;
    localparam logic [2:0] PAT_INV1 = 3'b011;
    localparam logic [2:0] PAT_BG2  = 3'b100;
    localparam logic [2:0] PAT_INV2 = 3'b101;

    localparam int NUM_BG = 3;

    // Background index plus inversion flag to the decoder select code.
    function automatic logic [2:0] pat_code(input logic [1:0] bg, input logic inv);
        logic [2:0] code;
        case ({bg, inv})
            3'b000:  code = PAT_BG0;
            3'b001:  code = PAT_INV0;
            3'b010:  code = PAT_BG1;
            3'b011:  code = PAT_INV1;
            3'b100:  code = PAT_BG2;
            3'b101:  code = PAT_INV2;
            default: code = PAT_BG0;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbist_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : mbist_addr_counter
// Description : Up/down address counter with load-low/load-high and end flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_addr_counter #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_lo,
    input  logic                  load_hi,
    input  logic                  inc,
    input  logic                  dec,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  at_min,
    output logic                  at_max
);

    logic [ADDR_WIDTH-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (load_lo) begin
            r_addr <= '0;
        end else if (load_hi) begin
            r_addr <= '1;
        end else if (inc) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
        end else if (dec) begin
            r_addr <= r_addr - ADDR_WIDTH'(1);
        end
    end

    assign addr   = r_addr;
    assign at_min = (r_addr == '0);
    assign at_max = (r_addr == '1);

endmodule
`default_nettype wire

// File: rtl/mbist_controller.sv
`default_nettype none
// ============================================================================
// Module      : mbist_controller
// Description : March-test sequencer over three data backgrounds, stop on first fail.
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_controller
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_q,
    output logic [2:0]            q,
    input  logic [DATA_WIDTH-1:0] data_t,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] C_LAST_BG = 2'(NUM_BG - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_bg;
    logic                  r_done;
    logic                  r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [2:0]            r_fail_q;

    logic                  w_load_lo;
    logic                  w_load_hi;
    logic                  w_inc;
    logic                  w_dec;
    logic                  w_at_min;
    logic                  w_at_max;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_launch;
    logic                  w_compare;
    logic                  w_bg_inc;
    logic                  w_mismatch;
    logic [2:0]            w_q;
    logic                  w_we;
    logic                  w_re;

    mbist_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_lo (w_load_lo),
        .load_hi (w_load_hi),
        .inc     (w_inc),
        .dec     (w_dec),
        .addr    (w_addr),
        .at_min  (w_at_min),
        .at_max  (w_at_max)
    );

    // Only feeds next-state and capture logic, never an output directly.
    assign w_mismatch = (mem_rdata != data_t);

    always_comb begin
        w_state_next = r_state;
        w_load_lo    = 1'b0;
        w_load_hi    = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_launch     = 1'b0;
        w_compare    = 1'b0;
        w_bg_inc     = 1'b0;
        w_q          = PAT_BG0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_launch     = 1'b1;
                    w_load_lo    = 1'b1;
                    w_state_next = ST_M0_W;
                end
            end
            ST_M0_W: begin
                w_we = 1'b1;
                w_q  = pat_code(r_bg, 1'b0);
                if (w_at_max) begin
                    w_load_lo    = 1'b1;
                    w_state_next = ST_M1_R;
                end else begin
                    w_inc = 1'b1;
                end
            end
            ST_M1_R: begin
                w_re         = 1'b1;
                w_q          = pat_code(r_bg, 1'b0);
                w_state_next = ST_M1_C;
            end
            ST_M1_C: begin
                w_q          = pat_code(r_bg, 1'b0);
                w_compare    = 1'b1;
                w_state_next = w_mismatch ? ST_DONE : ST_M1_W;
            end
            ST_M1_W: begin
                w_we = 1'b1;
                w_q  = pat_code(r_bg, 1'b1);
                if (w_at_max) begin
                    w_load_hi    = 1'b1;
                    w_state_next = ST_M2_R;
                end else begin
                    w_inc        = 1'b1;
                    w_state_next = ST_M1_R;
                end
            end
            ST_M2_R: begin
                w_re         = 1'b1;
                w_q          = pat_code(r_bg, 1'b1);
                w_state_next = ST_M2_C;
            end
            ST_M2_C: begin
                w_q          = pat_code(r_bg, 1'b1);
                w_compare    = 1'b1;
                w_state_next = w_mismatch ? ST_DONE : ST_M2_W;
            end
            ST_M2_W: begin
                w_we = 1'b1;
                w_q  = pat_code(r_bg, 1'b0);
                if (w_at_min) begin
                    w_load_hi    = 1'b1;
                    w_state_next = ST_M3_R;
                end else begin
                    w_dec        = 1'b1;
                    w_state_next = ST_M2_R;
                end
            end
            ST_M3_R: begin
                w_re         = 1'b1;
                w_q          = pat_code(r_bg, 1'b0);
                w_state_next = ST_M3_C;
            end
            ST_M3_C: begin
                w_q       = pat_code(r_bg, 1'b0);
                w_compare = 1'b1;
                if (w_mismatch) begin
                    w_state_next = ST_DONE;
                end else if (w_at_min) begin
                    w_state_next = ST_NEXT_BG;
                end else begin
                    w_dec        = 1'b1;
                    w_state_next = ST_M3_R;
                end
            end
            ST_NEXT_BG: begin
                if (r_bg == C_LAST_BG) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_bg_inc     = 1'b1;
                    w_load_lo    = 1'b1;
                    w_state_next = ST_M0_W;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bg        <= 2'd0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_q    <= PAT_BG0;
        end else begin
            r_state <= w_state_next;
            // A launch from DONE drops done on the same edge the test restarts.
            r_done  <= (r_state == ST_DONE) && !start;
            if (w_launch) begin
                r_bg        <= 2'd0;
                r_fail      <= 1'b0;
                r_fail_addr <= '0;
                r_fail_q    <= PAT_BG0;
            end else begin
                if (w_bg_inc) begin
                    r_bg <= r_bg + 2'd1;
                end
                if (w_compare && w_mismatch) begin
                    r_fail      <= 1'b1;
                    r_fail_addr <= w_addr;
                    r_fail_q    <= w_q;
                end
            end
        end
    end

    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done      = r_done;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_q    = r_fail_q;
    assign q         = w_q;
    assign mem_addr  = w_addr;
    assign mem_we    = w_we;
    assign mem_re    = w_re;
    assign mem_wdata = data_t;

endmodule
`default_nettype wire

// File: tb/tb_mbist_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mbist_controller
// Description : Self-checking bench: March-order reference model plus faulty SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mbist_controller;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail, mem_we, mem_re;
    logic [AW-1:0] fail_addr, mem_addr;
    logic [2:0]    fail_q, q;
    logic [DW-1:0] data_t, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    mbist_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_q    (fail_q),
        .q         (q),
        .data_t    (data_t),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] decode(input logic [2:0] code);
        case (code)
            3'd0:    return 8'hAA;
            3'd1:    return 8'h55;
            3'd2:    return 8'hCC;
            3'd3:    return 8'h33;
            3'd4:    return 8'hF0;
            3'd5:    return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    assign data_t = decode(q);

    // Faulty SRAM: a single cell whose read value has bits forced low/high.
    logic [AW-1:0] f_addr = '0;
    logic [DW-1:0] f_and  = 8'hFF;
    logic [DW-1:0] f_or   = 8'h00;
    logic [DW-1:0] mem [N];

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
        return (a == f_addr) ? ((v & f_and) | f_or) : v;
    endfunction

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= faulty(mem_addr, mem[mem_addr]);
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the March test written as a list of per-cycle operations.
    typedef struct packed {
        logic          we;
        logic          re;
        logic          cmp;
        logic [AW-1:0] addr;
        logic [2:0]    q;
    } op_t;

    op_t ops[$];
    int  exp_len, exp_done_k, done_k;
    logic          exp_fail;
    logic [AW-1:0] exp_faddr;
    logic [2:0]    exp_fq;

    function automatic op_t mk(input logic we, input logic re, input logic cmp,
                               input int a, input int code);
        op_t o;
        o.we = we; o.re = re; o.cmp = cmp; o.addr = AW'(a); o.q = 3'(code);
        return o;
    endfunction

    task automatic build_model();
        logic [DW-1:0] mm [N];
        ops.delete();
        for (int b = 0; b < 3; b++) begin
            int bg  = 2 * b;
            int inv = 2 * b + 1;
            for (int a = 0; a < N; a++) ops.push_back(mk(1, 0, 0, a, bg));
            for (int a = 0; a < N; a++) begin
                ops.push_back(mk(0, 1, 0, a, bg));
                ops.push_back(mk(0, 0, 1, a, bg));
                ops.push_back(mk(1, 0, 0, a, inv));
            end
            for (int a = N - 1; a >= 0; a--) begin
                ops.push_back(mk(0, 1, 0, a, inv));
                ops.push_back(mk(0, 0, 1, a, inv));
                ops.push_back(mk(1, 0, 0, a, bg));
            end
            for (int a = N - 1; a >= 0; a--) begin
                ops.push_back(mk(0, 1, 0, a, bg));
                ops.push_back(mk(0, 0, 1, a, bg));
            end
            ops.push_back(mk(0, 0, 0, 0, 0));
        end
        for (int a = 0; a < N; a++) mm[a] = '0;
        exp_fail  = 1'b0;
        exp_faddr = '0;
        exp_fq    = '0;
        exp_len   = ops.size();
        for (int i = 0; i < ops.size(); i++) begin
            if (ops[i].we) mm[ops[i].addr] = decode(ops[i].q);
            if (ops[i].cmp && faulty(ops[i].addr, mm[ops[i].addr]) != decode(ops[i].q)) begin
                exp_fail  = 1'b1;
                exp_faddr = ops[i].addr;
                exp_fq    = ops[i].q;
                exp_len   = i + 1;
                break;
            end
        end
        exp_done_k = exp_fail ? exp_len + 1 : exp_len + 1;
    endtask

    // k counts clock edges after the one that samples start; outputs read #1 later.
    task automatic run_test(input int restart_at);
        int k;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        k      = 0;
        done_k = -1;
        check_eq("launch_clears", {busy, done, fail, fail_addr}, {1'b1, 1'b0, 1'b0, 4'd0});
        while (done_k < 0 && k < 27 * N + 40) begin
            if (k < exp_len) begin
                check_eq("op", {mem_we, mem_re, mem_addr, q},
                         {ops[k].we, ops[k].re, ops[k].addr, ops[k].q});
                if (ops[k].we) check_eq("wdata", mem_wdata, decode(ops[k].q));
            end else begin
                check_eq("quiet", {mem_we, mem_re}, 2'b00);
            end
            if (done) begin
                done_k = k;
            end else begin
                start = (k == restart_at);
                @(posedge clk);
                #1;
                start = 1'b0;
                k++;
            end
        end
        check_eq("done_cycle", 64'(done_k), 64'(exp_done_k));
        check_eq("result", {busy, fail, fail_addr, fail_q}, {1'b0, exp_fail, exp_faddr, exp_fq});
    endtask

    task automatic set_fault(input int a, input int bitpos, input logic sa1);
        f_addr = AW'(a);
        f_and  = sa1 ? 8'hFF : ~(8'h01 << bitpos);
        f_or   = sa1 ? (8'h01 << bitpos) : 8'h00;
    endtask

    task automatic clear_fault();
        f_addr = '0;
        f_and  = 8'hFF;
        f_or   = 8'h00;
    endtask

    initial begin
        #1;
        check_eq("reset_state", {busy, done, fail, fail_addr, fail_q, q, mem_addr, mem_we, mem_re}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        clear_fault();
        run_test(50);
        check_eq("pass_done_436", 64'(done_k), 64'd436);

        set_fault(5, 0, 1'b0);
        run_test(-1);
        check_eq("sa0_a5", {fail, fail_addr, fail_q}, {1'b1, 4'd5, 3'b001});

        set_fault(0, 7, 1'b1);
        run_test(-1);
        check_eq("sa1_a0_fail", fail, 1'b1);

        clear_fault();
        run_test(-1);
        check_eq("rerun_clean", {done, fail, fail_addr}, {1'b1, 1'b0, 4'd0});

        // Asynchronous abort in the middle of a run.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_abort", {busy, done, fail, fail_addr, fail_q, q, mem_addr, mem_we, mem_re}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle_after_abort", {busy, mem_we, mem_re}, 3'b000);
        end
        run_test(-1);
        check_eq("after_abort_436", 64'(done_k), 64'd436);

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(3) == 0) clear_fault();
            else set_fault(int'($urandom_range(N - 1)), int'($urandom_range(7)), 1'($urandom_range(1)));
            run_test($urandom_range(1) == 1 ? int'($urandom_range(300)) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
